dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline outputs.
- Turns the stage's load/store control (MEM_Control_M, MEM_W_En_M, Result_Src_Sel_M) plus ALU_Out_M/SrcB_Reg_M into a registered req/ack data-memory bus transaction with byte-lane steering.
- Stalls the pipeline until the access completes and returns sign/zero-extended load data toward MEM/WB.
- Detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without DMEM_Ack before the access is aborted (1..255).

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
MEM_W_En_M  input  1  store request
Result_Src_Sel_M  input  2  2'b01 = load; any other value = not a load
MEM_Control_M  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALU_Out_M  input  32  byte address
SrcB_Reg_M  input  32  store data
DMEM_Req  output  1  bus request, registered
DMEM_We  output  1  bus write, registered
DMEM_Addr  output  32  word address {ALU_Out_M[31:2],2'b00}, registered
DMEM_BE  output  4  byte enables, registered
DMEM_WData  output  32  lane-replicated store data, registered
DMEM_Ack  input  1  bus completion, sampled in WAIT only
DMEM_RData  input  32  read word, valid with DMEM_Ack
Load_Data_M  output  32  extended load result, registered
Stall_M  output  1  hold IF..MEM
Misaligned_M  output  1  combinational misalignment flag
Bus_Err_M  output  1  one-cycle timeout pulse

Behaviour:
- Clock/reset: one clock CLK; synchronous active-high RST.
- Reset values: state IDLE; DMEM_Req/We 0; DMEM_Addr/BE/WData 0; Load_Data_M 0; Bus_Err_M 0; timeout counter 0. RST in any state aborts the access with no further Req.
- Access present when MEM_W_En_M=1 or Result_Src_Sel_M=2'b01. If both are set, it is a store.
- funct3 011/110/111 is treated as word.
- Misaligned when:
  - half and ALU_Out_M[0]=1; or
  - word and ALU_Out_M[1:0]!=0.
  Misaligned_M=1 that cycle, no bus request, Stall_M=0, Load_Data_M unchanged.
- Store lanes:
  - SB: BE=4'b0001<<addr[1:0], WData={4{SrcB[7:0]}}.
  - SH: BE=addr[1]?4'b1100:4'b0011, WData={2{SrcB[15:0]}}.
  - SW: BE=4'b1111, WData=SrcB.
- Loads drive BE=4'b1111, We=0.
- Load extract: byte = RData >> (8*addr[1:0]) [7:0]; half = RData >> (16*addr[1]) [15:0]; sign-extend for B/H, zero-extend for BU/HU.
- FSM:
  - IDLE: aligned access present → register Addr/BE/WData/We, Req=1, counter=0, go WAIT. Stall_M=1.
  - WAIT: Req held 1, outputs stable. Stall_M=1.
    - Ack=1 → Req=0; on a load, Load_Data_M=extracted value; go DONE.
    - Else counter+1; when counter reaches TIMEOUT_CYCLES-1 without Ack → Req=0, Bus_Err_M=1 next cycle, Load_Data_M=0 on a load, go DONE.
  - DONE: Stall_M=0 so the instruction leaves MEM at this edge; Bus_Err_M is high here if timed out; go IDLE unconditionally. DMEM_Ack in DONE/IDLE is ignored.
- Stall_M = access present & aligned & state!=DONE.
- Minimum latency: 2 stall cycles (Ack in first WAIT cycle).
- Back-to-back accesses: DONE→IDLE→WAIT, so consecutive memory instructions each take ≥3 cycles in MEM.
- Load_Data_M holds its value until the next load completes; stores never change it.

Test Plan:
- Aligned LW: addr 0x100, Ack with RData 0xDEADBEEF in first WAIT cycle → Req high one cycle, Stall_M high 2 cycles, DONE cycle Load_Data_M=0xDEADBEEF, Stall_M=0.
- LB at 0x103 with RData 0x80FF_0000 → Load_Data_M=0xFFFFFF80; LBU at 0x103 → 0x00000080; LHU at 0x102 → 0x000080FF.
- SB at 0x201 with SrcB=0x12345678 → DMEM_Addr=0x200, BE=4'b0010, WData=0x78787878, We=1; SH at 0x202 → BE=4'b1100, WData=0x56785678.
- LW at 0x102 and SH at 0x203 → Misaligned_M=1, Req never asserted, Stall_M=0, Load_Data_M unchanged.
- TIMEOUT_CYCLES=4, Ack never returned → Req high exactly 4 cycles, then Bus_Err_M=1 one cycle in DONE, Load_Data_M=0, Stall_M drops.
- Ack delayed 3 WAIT cycles with RST asserted in 2nd WAIT cycle → next cycle IDLE, Req=0, Load_Data_M=0; a later Ack is ignored.

Source files
------------

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Purpose  : Memory-stage data-memory access unit. Converts EX/MEM load/store
//            control into a registered req/ack bus transaction with byte-lane
//            steering, stalls the pipeline until completion, returns the
//            extended load value, and flags misalignment and bus timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MEM_W_En_M,
   input  logic [1:0]  Result_Src_Sel_M,
   input  logic [2:0]  MEM_Control_M,
   input  logic [31:0] ALU_Out_M,
   input  logic [31:0] SrcB_Reg_M,
   output logic        DMEM_Req,
   output logic        DMEM_We,
   output logic [31:0] DMEM_Addr,
   output logic [3:0]  DMEM_BE,
   output logic [31:0] DMEM_WData,
   input  logic        DMEM_Ack,
   input  logic [31:0] DMEM_RData,
   output logic [31:0] Load_Data_M,
   output logic        Stall_M,
   output logic        Misaligned_M,
   output logic        Bus_Err_M
);

   localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic        req_q, we_q, bus_err_q, ld_q;
   logic [31:0] addr_q, wdata_q, ld_data_q;
   logic [3:0]  be_q;
   logic [7:0]  cnt_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        is_store, is_load, access, is_half, is_word, misaligned, go;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, ext_d;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Access decode; a store wins when both store and load are flagged.
   // funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111 as word).
   assign is_store   = MEM_W_En_M;
   assign is_load    = (Result_Src_Sel_M == 2'b01);
   assign access     = is_store | is_load;
   assign is_half    = (MEM_Control_M[1:0] == 2'b01);
   assign is_word    = MEM_Control_M[1];
   assign misaligned = access & ((is_half & ALU_Out_M[0]) |
                                 (is_word & (ALU_Out_M[1:0] != 2'b00)));
   assign go         = access & ~misaligned;

   // Byte-lane steering for the request captured in IDLE.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = 32'h0;
      if (is_store) begin
         if (is_word) begin
            wdata_d = SrcB_Reg_M;
         end else if (is_half) begin
            be_d    = ALU_Out_M[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{SrcB_Reg_M[15:0]}};
         end else begin
            be_d    = 4'b0001 << ALU_Out_M[1:0];
            wdata_d = {4{SrcB_Reg_M[7:0]}};
         end
      end
   end

   // Load lane extraction using the size/offset latched at request time.
   always_comb begin
      case (off_q)
         2'd0:    ld_byte = DMEM_RData[7:0];
         2'd1:    ld_byte = DMEM_RData[15:8];
         2'd2:    ld_byte = DMEM_RData[23:16];
         default: ld_byte = DMEM_RData[31:24];
      endcase
      ld_half = off_q[1] ? DMEM_RData[31:16] : DMEM_RData[15:0];
      case (f3_q)
         3'b000:  ext_d = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ext_d = {24'h0, ld_byte};
         3'b001:  ext_d = {{16{ld_half[15]}}, ld_half};
         3'b101:  ext_d = {16'h0, ld_half};
         default: ext_d = DMEM_RData;
      endcase
   end

   // Transaction FSM with registered bus outputs, load result and error pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         be_q      <= 4'h0;
         wdata_q   <= 32'h0;
         ld_data_q <= 32'h0;
         bus_err_q <= 1'b0;
         cnt_q     <= 8'h0;
         ld_q      <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
      end else begin
         bus_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (go) begin
                  req_q   <= 1'b1;
                  we_q    <= is_store;
                  addr_q  <= {ALU_Out_M[31:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  cnt_q   <= 8'h0;
                  ld_q    <= ~is_store;
                  f3_q    <= MEM_Control_M;
                  off_q   <= ALU_Out_M[1:0];
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (DMEM_Ack) begin
                  req_q   <= 1'b0;
                  if (ld_q) ld_data_q <= ext_d;
                  state_q <= ST_DONE;
               end else if (cnt_q == C_TMO_LAST) begin
                  req_q     <= 1'b0;
                  bus_err_q <= 1'b1;
                  if (ld_q) ld_data_q <= 32'h0;
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign DMEM_Req     = req_q;
   assign DMEM_We      = we_q;
   assign DMEM_Addr    = addr_q;
   assign DMEM_BE      = be_q;
   assign DMEM_WData   = wdata_q;
   assign Load_Data_M  = ld_data_q;
   assign Bus_Err_M    = bus_err_q;
   assign Misaligned_M = misaligned;
   assign Stall_M      = go & (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_unit
// Purpose  : Self-checking bench for dmem_access_unit: directed vector table,
//            reset-abort sequence and randomized accesses against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

   localparam int TMO = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        MEM_W_En_M;
   logic [1:0]  Result_Src_Sel_M;
   logic [2:0]  MEM_Control_M;
   logic [31:0] ALU_Out_M, SrcB_Reg_M;
   logic        DMEM_Req, DMEM_We;
   logic [31:0] DMEM_Addr, DMEM_WData;
   logic [3:0]  DMEM_BE;
   logic        DMEM_Ack;
   logic [31:0] DMEM_RData;
   logic [31:0] Load_Data_M;
   logic        Stall_M, Misaligned_M, Bus_Err_M;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [31:0] exp_ld;

   always #5 CLK = ~CLK;

   dmem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .MEM_W_En_M(MEM_W_En_M), .Result_Src_Sel_M(Result_Src_Sel_M),
      .MEM_Control_M(MEM_Control_M), .ALU_Out_M(ALU_Out_M), .SrcB_Reg_M(SrcB_Reg_M),
      .DMEM_Req(DMEM_Req), .DMEM_We(DMEM_We), .DMEM_Addr(DMEM_Addr),
      .DMEM_BE(DMEM_BE), .DMEM_WData(DMEM_WData),
      .DMEM_Ack(DMEM_Ack), .DMEM_RData(DMEM_RData),
      .Load_Data_M(Load_Data_M), .Stall_M(Stall_M),
      .Misaligned_M(Misaligned_M), .Bus_Err_M(Bus_Err_M)
   );

   typedef struct {
      logic        we;
      logic [1:0]  rsel;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] srcb;
      logic [31:0] rdata;
      int          delay;
      logic        e_mis;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic        e_err;
      logic        upd;
      logic [31:0] e_ld;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   task automatic idle_inputs();
      MEM_W_En_M = 1'b0; Result_Src_Sel_M = 2'b00; MEM_Control_M = 3'b000;
      ALU_Out_M = 32'h0; SrcB_Reg_M = 32'h0;
   endtask

   // Spec-level model: sizes in bytes, lanes by arithmetic, extension by value range.
   task automatic ref_model(input logic we, input logic [1:0] rsel, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] srcb,
                            input logic [31:0] rdata, input int delay,
                            output logic e_mis, output logic [3:0] e_be,
                            output logic [31:0] e_wd, output logic e_err,
                            output logic upd, output logic [31:0] e_ld);
      int size, off;
      bit acc, uns;
      logic [31:0] v;
      acc = we || (rsel == 2'b01);
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      uns   = (f3 >= 3'd4) && (size < 4);
      off   = int'(addr % 4);
      e_mis = acc && ((off % size) != 0);
      e_be  = we ? 4'(((1 << size) - 1) << off) : 4'hF;
      case (size)
         1:       e_wd = {24'h0, srcb[7:0]}  * 32'h0101_0101;
         2:       e_wd = {16'h0, srcb[15:0]} * 32'h0001_0001;
         default: e_wd = srcb;
      endcase
      e_err = acc && !e_mis && (delay >= TMO);
      upd   = acc && !e_mis && !we;
      if (e_err) e_ld = 32'h0;
      else begin
         v = rdata >> (8 * off);
         if (size < 4) begin
            v = v % (32'h1 << (8 * size));
            if (!uns && v >= (32'h1 << (8 * size - 1))) v = v - (32'h1 << (8 * size));
         end
         e_ld = v;
      end
   endtask

   task automatic do_access(input vec_t t, input string tag);
      logic acc;
      acc = t.we || (t.rsel == 2'b01);
      @(posedge CLK); #1;
      MEM_W_En_M = t.we; Result_Src_Sel_M = t.rsel; MEM_Control_M = t.f3;
      ALU_Out_M = t.addr; SrcB_Reg_M = t.srcb;
      @(negedge CLK);
      check({tag, " misaligned"}, 32'(Misaligned_M), 32'(t.e_mis));
      if (!acc || t.e_mis) begin
         check({tag, " stall_noacc"}, 32'(Stall_M), 32'h0);
         @(posedge CLK); #1;
         @(negedge CLK);
         check({tag, " req_noacc"}, 32'(DMEM_Req), 32'h0);
         check({tag, " ld_unchanged"}, Load_Data_M, exp_ld);
         idle_inputs();
         return;
      end
      check({tag, " stall_idle"}, 32'(Stall_M), 32'h1);
      check({tag, " req_idle"}, 32'(DMEM_Req), 32'h0);
      @(posedge CLK);
      for (int k = 0; k < TMO; k++) begin
         @(negedge CLK);
         check({tag, " req_wait"}, 32'(DMEM_Req), 32'h1);
         check({tag, " stall_wait"}, 32'(Stall_M), 32'h1);
         check({tag, " addr"}, DMEM_Addr, t.addr & 32'hFFFF_FFFC);
         check({tag, " be"}, 32'(DMEM_BE), 32'(t.e_be));
         check({tag, " we"}, 32'(DMEM_We), 32'(t.we));
         if (t.we) check({tag, " wdata"}, DMEM_WData, t.e_wd);
         if (k == t.delay) begin DMEM_Ack = 1'b1; DMEM_RData = t.rdata; end
         @(posedge CLK); #1;
         DMEM_Ack = 1'b0; DMEM_RData = 32'hA5A5_A5A5;
         if (k == t.delay) break;
      end
      // DONE cycle: a stray Ack here must be ignored.
      @(negedge CLK);
      if (t.upd) exp_ld = t.e_ld;
      check({tag, " req_done"}, 32'(DMEM_Req), 32'h0);
      check({tag, " stall_done"}, 32'(Stall_M), 32'h0);
      check({tag, " buserr_done"}, 32'(Bus_Err_M), 32'(t.e_err));
      check({tag, " ld_done"}, Load_Data_M, exp_ld);
      DMEM_Ack = 1'b1; DMEM_RData = 32'h1357_9BDF;
      @(posedge CLK); #1;
      DMEM_Ack = 1'b0;
      idle_inputs();
      @(negedge CLK);
      check({tag, " buserr_after"}, 32'(Bus_Err_M), 32'h0);
      check({tag, " req_after"}, 32'(DMEM_Req), 32'h0);
      check({tag, " ld_after"}, Load_Data_M, exp_ld);
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      //       we  rsel   f3     addr          srcb          rdata         dly mis be       wdata          err upd ld
      tbl.push_back('{1'b0, 2'b01, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF});
      tbl.push_back('{1'b0, 2'b01, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'hFFFF_FF80});
      tbl.push_back('{1'b0, 2'b01, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_0080});
      tbl.push_back('{1'b0, 2'b01, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_0000, 2, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_80FF});
      tbl.push_back('{1'b0, 2'b01, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'hFFFF_80FF});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'h0,        2, 1'b0, 4'b0010, 32'h7878_7878, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 2'b00, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0,        0, 1'b0, 4'b1100, 32'h5678_5678, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 2'b00, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'h0,        1, 1'b0, 4'b1111, 32'h1234_5678, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 2'b01, 3'b010, 32'h0000_0102, 32'h0,        32'h0,         0, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 2'b00, 3'b001, 32'h0000_0203, 32'hAAAA_5555, 32'h0,        0, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 2'b10, 3'b010, 32'h0000_0103, 32'h0,        32'h0,         0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 2'b01, 3'b110, 32'h0000_0108, 32'h0,        32'hCAFE_F00D, 3, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D});
      tbl.push_back('{1'b0, 2'b01, 3'b010, 32'h0000_010C, 32'h0,        32'h1111_1111, 4, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 2'b01, 3'b010, 32'h0000_0300, 32'h0BAD_F00D, 32'h7777_7777, 0, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 2'b00, 3'b001, 32'h0000_0302, 32'h0000_BEEF, 32'h0,        5, 1'b0, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 2'b01, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_007F});

      idle_inputs();
      DMEM_Ack = 1'b0; DMEM_RData = 32'h0;
      RST = 1'b1;
      exp_ld = 32'h0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst req", 32'(DMEM_Req), 32'h0);
      check("rst we", 32'(DMEM_We), 32'h0);
      check("rst addr", DMEM_Addr, 32'h0);
      check("rst be", 32'(DMEM_BE), 32'h0);
      check("rst wdata", DMEM_WData, 32'h0);
      check("rst ld", Load_Data_M, 32'h0);
      check("rst buserr", 32'(Bus_Err_M), 32'h0);
      check("rst stall", 32'(Stall_M), 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;

      foreach (tbl[i]) do_access(tbl[i], $sformatf("vec%0d", i));

      // Reset during the second WAIT cycle of a load whose Ack would come in the third.
      @(posedge CLK); #1;
      Result_Src_Sel_M = 2'b01; MEM_Control_M = 3'b010; ALU_Out_M = 32'h0000_0400;
      @(posedge CLK);
      @(negedge CLK);
      check("rstw req_w1", 32'(DMEM_Req), 32'h1);
      @(posedge CLK); #1;
      RST = 1'b1;
      idle_inputs();
      @(posedge CLK); #1;
      RST = 1'b0;
      DMEM_Ack = 1'b1; DMEM_RData = 32'h2468_ACE0;
      exp_ld = 32'h0;
      @(negedge CLK);
      check("rstw req", 32'(DMEM_Req), 32'h0);
      check("rstw stall", 32'(Stall_M), 32'h0);
      check("rstw ld", Load_Data_M, exp_ld);
      check("rstw buserr", 32'(Bus_Err_M), 32'h0);
      @(posedge CLK); #1;
      DMEM_Ack = 1'b0;
      @(negedge CLK);
      check("rstw late_ack_ld", Load_Data_M, exp_ld);
      check("rstw late_ack_req", 32'(DMEM_Req), 32'h0);

      // Randomized accesses checked against the model.
      for (int n = 0; n < 80; n++) begin
         rv.we    = ($urandom_range(0, 2) == 0);
         rv.rsel  = 2'($urandom_range(0, 3));
         rv.f3    = 3'($urandom_range(0, 7));
         rv.addr  = $urandom;
         rv.srcb  = $urandom;
         rv.rdata = $urandom;
         rv.delay = $urandom_range(0, 5);
         ref_model(rv.we, rv.rsel, rv.f3, rv.addr, rv.srcb, rv.rdata, rv.delay,
                   rv.e_mis, rv.e_be, rv.e_wd, rv.e_err, rv.upd, rv.e_ld);
         do_access(rv, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
